alu_resp_tx: RTL and testbench

ALU_RESP_TX -- requirements
Module: alu_resp_tx

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_frame_ser.sv | 108 ++++++++++
 rtl/alu_resp_tx.sv | 101 ++++++++++
 tb/tb_alu_resp_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU response transmitter.
package alu_pkg;

  // Transmitter state encoding; plain constants keep older tools happy.
  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE    = 2'd0;
  localparam tx_state_t ST_START   = 2'd1;
  localparam tx_state_t ST_PAYLOAD = 2'd2;
  localparam tx_state_t ST_STOP    = 2'd3;

  // Frame type bit: the status frame is marked so a receiver can resync.
  localparam logic FRAME_CMD  = 1'b1;
  localparam logic FRAME_DATA = 1'b0;

  // Status codes carried in the first frame.
  localparam logic [7:0] S_OK              = 8'h00;
  localparam logic [7:0] S_INVALID_COMMAND = 8'h01;
  localparam logic [7:0] S_DIV_BY_ZERO     = 8'h02;
  localparam logic [7:0] S_OVERFLOW        = 8'h03;

  // Frame geometry: start + 10-bit payload + stop; three frames per response.
  localparam int unsigned FRAME_BITS      = 12;
  localparam int unsigned PAYLOAD_BITS    = 10;
  localparam int unsigned FRAMES_PER_RESP = 3;

  // Even parity over type + data, so XOR of the whole payload is zero.
  function automatic logic frame_parity(input logic ftype, input logic [7:0] data);
    return ftype ^ (^data);
  endfunction

endpackage

// File: rtl/alu_frame_ser.sv
// Serializes one 12-bit frame: start, type, data MSB first, parity, stop.
// A new frame may be loaded in the last cycle of the stop bit so frames
// run back-to-back without idle bits.
module alu_frame_ser
  import alu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       frame_type,
  input  logic [7:0] data,
  output logic       sout,
  output tx_state_t  state,
  output logic       frame_end
);

  localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [3:0] BIT_LAST  = 4'(PAYLOAD_BITS - 1);

  tx_state_t   state_q, state_d;
  logic [7:0]  baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  // Bits still to be driven after the current one; refilled with ones.
  logic [10:0] shreg_q, shreg_d;
  logic        sout_q, sout_d;
  logic        tick;

  assign tick = (baud_q == BAUD_LAST);

  // Next-state logic: bit timing, payload shifting and frame phase.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sout_d  = sout_q;

    if (state_q != ST_IDLE) begin
      baud_d = tick ? 8'd0 : baud_q + 8'd1;
    end

    if (load) begin
      state_d = ST_START;
      baud_d  = 8'd0;
      bit_d   = 4'd0;
      shreg_d = {frame_type, data, frame_parity(frame_type, data), 1'b1};
      sout_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          sout_d = 1'b1;
        end
        ST_START: begin
          if (tick) begin
            state_d           = ST_PAYLOAD;
            bit_d             = 4'd0;
            {sout_d, shreg_d} = {shreg_q, 1'b1};
          end
        end
        ST_PAYLOAD: begin
          if (tick) begin
            {sout_d, shreg_d} = {shreg_q, 1'b1};
            if (bit_q == BIT_LAST) begin
              state_d = ST_STOP;
              bit_d   = 4'd0;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_d = ST_IDLE;
            sout_d  = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          sout_d  = 1'b1;
        end
      endcase
    end
  end

  // State registers; reset drives the line idle-high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      baud_q  <= 8'd0;
      bit_q   <= 4'd0;
      shreg_q <= 11'd0;
      sout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sout_q  <= sout_d;
    end
  end

  assign sout      = sout_q;
  assign state     = state_q;
  assign frame_end = (state_q == ST_STOP) && tick;

endmodule

// File: rtl/alu_resp_tx.sv
// ALU response transmitter: accepts status + result on a valid/ready
// handshake and sends them as three serial frames (status, result high,
// result low).
module alu_resp_tx
  import alu_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [7:0]  status,
  input  logic [15:0] result,
  output logic        sout,
  output logic        busy,
  output logic        tx_done
);

  localparam logic [1:0] LAST_FRAME = 2'(FRAMES_PER_RESP - 1);

  tx_state_t   ser_state;
  logic        frame_end;
  logic        ready_q, ready_d;
  logic [1:0]  frame_idx_q, frame_idx_d;
  logic [7:0]  status_q, status_d;
  logic [15:0] result_q, result_d;
  logic        transfer;
  logic        last_frame;
  logic        load;
  logic        ld_type;
  logic [7:0]  ld_data;

  assign transfer   = rsp_valid && ready_q;
  assign last_frame = (frame_idx_q == LAST_FRAME);
  assign load       = transfer || (frame_end && !last_frame);

  // Pick the frame to load: status straight from the inputs on accept,
  // otherwise the next result byte from the captured copy.
  always_comb begin
    ld_type = FRAME_DATA;
    ld_data = result_q[7:0];
    if (transfer) begin
      ld_type = FRAME_CMD;
      ld_data = status;
    end else if (frame_idx_q == 2'd0) begin
      ld_data = result_q[15:8];
    end
  end

  // Handshake, capture and frame sequencing.
  always_comb begin
    status_d    = status_q;
    result_d    = result_q;
    frame_idx_d = frame_idx_q;
    ready_d     = (ser_state == ST_IDLE) && !transfer;
    if (transfer) begin
      status_d    = status;
      result_d    = result;
      frame_idx_d = 2'd0;
    end else if (frame_end) begin
      frame_idx_d = last_frame ? 2'd0 : frame_idx_q + 2'd1;
      if (last_frame) begin
        ready_d = 1'b1;
      end
    end
  end

  // Sequencer registers; ready stays low through reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      frame_idx_q <= 2'd0;
      status_q    <= 8'd0;
      result_q    <= 16'd0;
    end else begin
      ready_q     <= ready_d;
      frame_idx_q <= frame_idx_d;
      status_q    <= status_d;
      result_q    <= result_d;
    end
  end

  alu_frame_ser #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .frame_type(ld_type),
    .data      (ld_data),
    .sout      (sout),
    .state     (ser_state),
    .frame_end (frame_end)
  );

  assign rsp_ready = ready_q;
  assign busy      = (ser_state != ST_IDLE);
  assign tx_done   = frame_end && last_frame;

endmodule

// File: tb/tb_alu_resp_tx.sv
// Directed bench for alu_resp_tx at CLKS_PER_BIT = 1 and 4.
module tb_alu_resp_tx;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic        sel = 1'b0;
  logic [7:0]  st_in = 8'd0;
  logic [15:0] res_in = 16'd0;

  logic ready1, sout1, busy1, done1;
  logic ready4, sout4, busy4, done4;
  wire  valid1 = vin & ~sel;
  wire  valid4 = vin & sel;
  wire  ready_m = sel ? ready4 : ready1;
  wire  sout_m  = sel ? sout4 : sout1;
  wire  busy_m  = sel ? busy4 : busy1;
  wire  done_m  = sel ? done4 : done1;

  always #5 clk = ~clk;

  alu_resp_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .rsp_valid(valid1), .rsp_ready(ready1), .status(st_in),
    .result(res_in), .sout(sout1), .busy(busy1), .tx_done(done1)
  );

  alu_resp_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .rsp_valid(valid4), .rsp_ready(ready4), .status(st_in),
    .result(res_in), .sout(sout4), .busy(busy4), .tx_done(done4)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  logic cap_line [0:299];
  logic cap_busy [0:299];
  logic cap_done [0:299];
  logic cap_ready[0:299];

  // Record n cycles starting at the current falling edge.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_line[i]  = sout_m;
      cap_busy[i]  = busy_m;
      cap_done[i]  = done_m;
      cap_ready[i] = ready_m;
      @(negedge clk);
    end
  endtask

  // Offer a response, wait for acceptance, then record from the first start bit.
  task automatic send(input logic [7:0] st, input logic [15:0] res, input bit hold,
                      input bit change, input int win);
    int k;
    st_in  = st;
    res_in = res;
    vin    = 1'b1;
    k      = 0;
    while (!ready_m && k < 400) begin
      @(negedge clk);
      k++;
    end
    check_eq("handshake ready", ready_m, 1'b1);
    @(negedge clk);
    if (!hold) vin = 1'b0;
    if (change) begin
      res_in = 16'hABCD;
      st_in  = 8'hFF;
    end
    capture(win);
  endtask

  task automatic check_resp(input string tag, input int cpb, input logic [9:0] p0,
                            input logic [9:0] p1, input logic [9:0] p2);
    logic [9:0] pl, exp;
    int unstable, nbusy, ndone, done_at, base;
    for (int f = 0; f < 3; f++) begin
      base = f * 12;
      exp  = (f == 0) ? p0 : (f == 1) ? p1 : p2;
      for (int b = 0; b < 10; b++) pl[9-b] = cap_line[(base + 1 + b) * cpb];
      check_eq($sformatf("%s f%0d start", tag, f), cap_line[base * cpb], 1'b0);
      check_eq($sformatf("%s f%0d payload", tag, f), pl, exp);
      check_eq($sformatf("%s f%0d stop", tag, f), cap_line[(base + 11) * cpb + cpb - 1], 1'b1);
    end
    unstable = 0;
    for (int j = 0; j < 36; j++)
      for (int c = 1; c < cpb; c++)
        if (cap_line[j * cpb + c] !== cap_line[j * cpb]) unstable++;
    if (cpb > 1) check_eq($sformatf("%s unstable bits", tag), unstable, 0);
    nbusy = 0;
    for (int i = 0; i <= 36 * cpb; i++) if (cap_busy[i] === 1'b1) nbusy++;
    check_eq($sformatf("%s busy cycles", tag), nbusy, 36 * cpb);
    ndone   = 0;
    done_at = -1;
    for (int i = 0; i < 36 * cpb + 3; i++)
      if (cap_done[i] === 1'b1) begin
        ndone++;
        if (done_at < 0) done_at = i;
      end
    check_eq($sformatf("%s tx_done count", tag), ndone, 1);
    check_eq($sformatf("%s tx_done cycle", tag), done_at, 36 * cpb - 1);
    check_eq($sformatf("%s ready during tx", tag), cap_ready[0], 1'b0);
    check_eq($sformatf("%s ready after tx", tag), cap_ready[36 * cpb], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst sout1", sout1, 1'b1);
    check_eq("rst busy1", busy1, 1'b0);
    check_eq("rst ready1", ready1, 1'b0);
    check_eq("rst done1", done1, 1'b0);
    check_eq("rst sout4", sout4, 1'b1);
    check_eq("rst ready4", ready4, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("ready before first edge", ready1, 1'b0);
    @(negedge clk);
    check_eq("ready after first edge", ready1, 1'b1);

    // OK status, result 0x1234.
    send(S_OK, 16'h1234, 1'b0, 1'b0, 39);
    check_resp("r1234", 1, 10'b1_00000000_1, 10'b0_00010010_0, 10'b0_00110100_1);

    // Invalid command, zero result.
    send(S_INVALID_COMMAND, 16'h0000, 1'b0, 1'b0, 39);
    check_resp("rinv", 1, 10'b1_00000001_0, 10'b0_00000000_0, 10'b0_00000000_0);

    // Inputs change right after acceptance; captured values must be sent.
    send(S_OK, 16'h1234, 1'b0, 1'b1, 39);
    check_resp("rchg", 1, 10'b1_00000000_1, 10'b0_00010010_0, 10'b0_00110100_1);

    // Valid held high: one idle cycle, then the next response starts.
    send(S_OK, 16'h1234, 1'b1, 1'b0, 40);
    check_resp("rhold", 1, 10'b1_00000000_1, 10'b0_00010010_0, 10'b0_00110100_1);
    check_eq("hold gap line", cap_line[36], 1'b1);
    check_eq("hold gap busy", cap_busy[36], 1'b0);
    check_eq("hold next start", cap_line[37], 1'b0);
    check_eq("hold next busy", cap_busy[37], 1'b1);
    check_eq("hold next ready", cap_ready[37], 1'b0);
    vin = 1'b0;
    k = 0;
    while (!ready_m && k < 200) begin
      @(negedge clk);
      k++;
    end
    check_eq("hold drain", ready_m, 1'b1);

    // Four clocks per bit.
    sel = 1'b1;
    @(negedge clk);
    send(S_OK, 16'hFFFF, 1'b0, 1'b0, 147);
    check_resp("r4ffff", 4, 10'b1_00000000_1, 10'b0_11111111_0, 10'b0_11111111_0);
    sel = 1'b0;
    @(negedge clk);

    // Reset in the middle of F1 (data bit d3 of 0x12, a zero on the line).
    send(S_OK, 16'h1234, 1'b0, 1'b0, 0);
    repeat (18) @(negedge clk);
    check_eq("pre-reset line", sout1, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("mid rst sout", sout1, 1'b1);
    check_eq("mid rst busy", busy1, 1'b0);
    check_eq("mid rst ready", ready1, 1'b0);
    check_eq("mid rst done", done1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post rst ready early", ready1, 1'b0);
    @(negedge clk);
    check_eq("post rst ready", ready1, 1'b1);
    check_eq("post rst line idle", sout1, 1'b1);
    send(S_DIV_BY_ZERO, 16'h00FF, 1'b0, 1'b0, 39);
    check_resp("rpost", 1, 10'b1_00000010_0, 10'b0_00000000_0, 10'b0_11111111_0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
